quad_encoder: RTL and testbench
===============================

QUAD_ENCODER -- requirements
Module: quad_encoder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: width of the position counter.
REQ-002 The block SHALL have parameter DEBOUNCE, default 4: consecutive stable samples required (legal range 1..255).
REQ-003 The block SHALL have parameter SATURATE, default 1: 1 = clamp at 0 / 2^WIDTH-1; 0 = modulo wrap.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enc_a  input  1  raw, asynchronous quadrature channel A.
REQ-007 enc_b  input  1  raw, asynchronous quadrature channel B.
REQ-008 en  input  1  count enable; when low, synchronising, debouncing and phase tracking continue but value holds.
REQ-009 value  output  WIDTH  registered position count; feeds the downstream PWM duty input.
REQ-010 step  output  1  one-cycle pulse, high in the cycle after value changed.
REQ-011 dir  output  1  registered direction of the last valid transition (1 = up, 0 = down).
REQ-012 error  output  1  one-cycle pulse on an illegal transition.

Function
REQ-013 Each channel SHALL pass through a 2-flop synchroniser; output sync valid 2 edges after the raw change.
REQ-014 Per channel, a debounce counter SHALL behave as follows: sync != deb -> cnt+1; cnt reaches DEBOUNCE-1 -> deb <= sync, cnt <= 0; sync == deb -> cnt <= 0.
REQ-015 A glitch shorter than DEBOUNCE consecutive cycles SHALL leave deb unchanged and SHALL restart the count from 0.
REQ-016 The decoder SHALL register prev <= {deb_a, deb_b} every cycle and compare it combinationally with the current {deb_a, deb_b}.
REQ-017 Up sequence {a,b}: 00->10->11->01->00; each single-bit step along it SHALL be an up transition.
REQ-018 The reverse sequence SHALL be down transitions; x4 decoding, one count per valid transition.
REQ-019 A transition with both bits changed SHALL pulse error for one cycle and SHALL NOT change value or dir.
REQ-020 On a valid transition with en=1, value SHALL update on the same edge that prev updates; latency from a stable raw edge to value change = DEBOUNCE+3 clock edges.
REQ-021 With SATURATE=1: up at 2^WIDTH-1 and down at 0 SHALL leave value unchanged, produce no step pulse, and still update dir.
REQ-022 With SATURATE=0: value SHALL wrap 2^WIDTH-1 -> 0 (up) and 0 -> 2^WIDTH-1 (down).
REQ-023 step SHALL be high only when value actually changed on the previous edge.
REQ-024 With en=0, a valid transition SHALL update prev and dir and SHALL NOT change value or pulse step; no catch-up SHALL occur when en rises.
REQ-025 Step and error SHALL be mutually exclusive.

Reset
REQ-026 While reset is high at a clk edge: synchronisers, deb, cnt and prev SHALL go to 0; value, step, dir and error SHALL go to 0.
REQ-027 reset SHALL override en and any in-flight debounce or transition in the same edge.
REQ-028 An encoder resting at 11 through reset SHALL produce, after DEBOUNCE+3 edges, one error pulse and no count.

Verification
REQ-029 Reset, then one full up cycle 00->10->11->01->00, each phase held 10 cycles (DEBOUNCE=4) -> value = 4, four step pulses, dir = 1; first step exactly 7 edges after first raw change.
REQ-030 Reverse cycle from value 4 -> value = 0; then one more down step with SATURATE=1 -> value stays 0, no step, dir = 0.
REQ-031 SATURATE=0 at value 0, one down transition -> value = 255, step pulses once.
REQ-032 A 3-cycle pulse on enc_a with DEBOUNCE=4 -> no change to deb, value or step; a 4-cycle pulse -> one up then one down count.
REQ-033 Hold enc_a = enc_b = 1 through reset, release reset -> single error pulse at edge 7, value = 0.
REQ-034 en=0 during two up transitions, then en=1 plus one up -> value increments by 1 only; assert reset mid-debounce -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/quad_encoder_if.sv
// Quadrature encoder bus: raw channels and enable in, registered position out.
interface quad_encoder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             enc_a;
    logic             enc_b;
    logic             en;
    logic [WIDTH-1:0] value;
    logic             step;
    logic             dir;
    logic             error;

    // Controller side: drives the encoder pins and enable, consumes the count.
    modport master (
        output enc_a,
        output enc_b,
        output en,
        input  value,
        input  step,
        input  dir,
        input  error
    );

    // Decoder side: the quad_encoder block itself.
    modport slave (
        input  enc_a,
        input  enc_b,
        input  en,
        output value,
        output step,
        output dir,
        output error
    );
endinterface

// File: rtl/quad_encoder.sv
// Quadrature encoder front end: synchronise, debounce, x4 decode, position count.
module quad_encoder #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned SATURATE = 1
) (
    input  logic           clk,
    input  logic           reset,
    quad_encoder_if.slave  bus
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);
    localparam bit SAT = (SATURATE != 0);
    localparam logic [WIDTH-1:0] VALUE_ONE = WIDTH'(1);

    // Channel index 1 carries A, index 0 carries B, so {a,b} reads naturally.
    logic [1:0]       raw_c;
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [1:0]       deb_q;
    logic [CNT_W-1:0] cnt_q [2];
    logic [1:0]       prev_q;

    logic [WIDTH-1:0] value_q;
    logic             step_q;
    logic             dir_q;
    logic             error_q;

    logic [1:0]       pos_cur_c;
    logic [1:0]       pos_prev_c;
    logic [1:0]       delta_c;
    logic             up_c;
    logic             down_c;
    logic             err_c;
    logic             at_max_c;
    logic             at_min_c;
    logic [WIDTH-1:0] value_nxt_c;
    logic             changed_c;

    assign raw_c = {bus.enc_a, bus.enc_b};

    // Position of a phase along the up sequence 00 -> 10 -> 11 -> 01 -> 00.
    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        logic [1:0] pos;
        pos = 2'd0;
        case (ab)
            2'b00:   pos = 2'd0;
            2'b10:   pos = 2'd1;
            2'b11:   pos = 2'd2;
            2'b01:   pos = 2'd3;
            default: pos = 2'd0;
        endcase
        return pos;
    endfunction

    // Two-flop synchroniser on both raw channels.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= raw_c;
            sync2_q <= sync1_q;
        end
    end

    // Per-channel debounce: accept a new level after DEBOUNCE consecutive samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_q <= 2'b00;
            for (int ch = 0; ch < 2; ch++) begin
                cnt_q[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if (sync2_q[ch] != deb_q[ch]) begin
                    if (cnt_q[ch] == CNT_MAX) begin
                        deb_q[ch] <= sync2_q[ch];
                        cnt_q[ch] <= '0;
                    end else begin
                        cnt_q[ch] <= cnt_q[ch] + CNT_W'(1);
                    end
                end else begin
                    cnt_q[ch] <= '0;
                end
            end
        end
    end

    // Classify the debounced phase change: distance 1 is up, 3 is down, 2 is illegal.
    always_comb begin
        pos_cur_c  = gray_pos(deb_q);
        pos_prev_c = gray_pos(prev_q);
        delta_c    = 2'(pos_cur_c - pos_prev_c);
        up_c       = (delta_c == 2'd1);
        down_c     = (delta_c == 2'd3);
        err_c      = (delta_c == 2'd2);
    end

    // Next count: clamp or wrap at the ends, hold while disabled.
    always_comb begin
        value_nxt_c = value_q;
        at_max_c    = (value_q == '1);
        at_min_c    = (value_q == '0);
        if (bus.en) begin
            if (up_c) begin
                if (!(SAT && at_max_c)) begin
                    value_nxt_c = value_q + VALUE_ONE;
                end
            end else if (down_c) begin
                if (!(SAT && at_min_c)) begin
                    value_nxt_c = value_q - VALUE_ONE;
                end
            end
        end
        changed_c = (value_nxt_c != value_q);
    end

    // Phase history and registered outputs; prev and value move on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q  <= 2'b00;
            value_q <= '0;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
            error_q <= 1'b0;
        end else begin
            prev_q  <= deb_q;
            value_q <= value_nxt_c;
            step_q  <= changed_c;
            error_q <= err_c;
            if (up_c || down_c) begin
                dir_q <= up_c;
            end
        end
    end

    assign bus.value = value_q;
    assign bus.step  = step_q;
    assign bus.dir   = dir_q;
    assign bus.error = error_q;

endmodule

// File: tb/tb_quad_encoder.sv
// Directed bench: a clamping and a wrapping quad_encoder share one stimulus.
module tb_quad_encoder;

    logic clk;
    logic reset;
    logic enc_a;
    logic enc_b;
    logic en;

    int vectors;
    int miscompares;
    int st0;
    int st1;
    int er0;
    int er1;
    int base_st0;
    int base_st1;
    int base_er0;

    quad_encoder_if #(.WIDTH(8)) bus0 ();
    quad_encoder_if #(.WIDTH(8)) bus1 ();

    assign bus0.enc_a = enc_a;
    assign bus0.enc_b = enc_b;
    assign bus0.en    = en;
    assign bus1.enc_a = enc_a;
    assign bus1.enc_b = enc_b;
    assign bus1.en    = en;

    quad_encoder #(.WIDTH(8), .DEBOUNCE(4), .SATURATE(1)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    quad_encoder #(.WIDTH(8), .DEBOUNCE(4), .SATURATE(0)) dut_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse tallies, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus0.step)  st0 <= st0 + 1;
        if (bus1.step)  st1 <= st1 + 1;
        if (bus0.error) er0 <= er0 + 1;
        if (bus1.error) er1 <= er1 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Move to a new phase and hold it for 10 cycles.
    task automatic phase(input logic a, input logic b);
        enc_a = a;
        enc_b = b;
        cyc(10);
    endtask

    task automatic snap();
        base_st0 = st0;
        base_st1 = st1;
        base_er0 = er0;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        st0 = 0; st1 = 0; er0 = 0; er1 = 0;
        reset = 1'b1; enc_a = 1'b0; enc_b = 1'b0; en = 1'b1;
        cyc(3);
        chk("rst_value", 32'(bus0.value), 32'd0);
        chk("rst_step",  32'(bus0.step),  32'd0);
        chk("rst_dir",   32'(bus0.dir),   32'd0);
        chk("rst_error", 32'(bus0.error), 32'd0);
        reset = 1'b0;
        cyc(3);
        snap();

        // Full up cycle; first count lands 7 edges after the raw change.
        enc_a = 1'b1;
        cyc(6);
        chk("lat_value_e6", 32'(bus0.value), 32'd0);
        chk("lat_step_e6",  32'(bus0.step),  32'd0);
        cyc(1);
        chk("lat_value_e7", 32'(bus0.value), 32'd1);
        chk("lat_step_e7",  32'(bus0.step),  32'd1);
        chk("lat_dir_e7",   32'(bus0.dir),   32'd1);
        cyc(1);
        chk("lat_step_e8",  32'(bus0.step),  32'd0);
        cyc(2);
        phase(1'b1, 1'b1);
        phase(1'b0, 1'b1);
        phase(1'b0, 1'b0);
        chk("up_value",  32'(bus0.value), 32'd4);
        chk("up_dir",    32'(bus0.dir),   32'd1);
        chk("up_steps",  32'(st0 - base_st0), 32'd4);
        chk("up_value_wrapdut", 32'(bus1.value), 32'd4);

        // Reverse cycle back to zero.
        snap();
        phase(1'b0, 1'b1);
        chk("dn_value_3", 32'(bus0.value), 32'd3);
        phase(1'b1, 1'b1);
        phase(1'b1, 1'b0);
        phase(1'b0, 1'b0);
        chk("dn_value", 32'(bus0.value), 32'd0);
        chk("dn_dir",   32'(bus0.dir),   32'd0);
        chk("dn_steps", 32'(st0 - base_st0), 32'd4);

        // One more down: clamp on one instance, wrap on the other.
        snap();
        phase(1'b0, 1'b1);
        chk("sat_value",  32'(bus0.value), 32'd0);
        chk("sat_steps",  32'(st0 - base_st0), 32'd0);
        chk("sat_dir",    32'(bus0.dir),   32'd0);
        chk("wrap_value", 32'(bus1.value), 32'd255);
        chk("wrap_steps", 32'(st1 - base_st1), 32'd1);

        // Up from the wrapped end goes back to zero.
        snap();
        phase(1'b0, 1'b0);
        chk("sat_up_value",  32'(bus0.value), 32'd1);
        chk("wrap_up_value", 32'(bus1.value), 32'd0);
        chk("wrap_up_dir",   32'(bus1.dir),   32'd1);
        chk("wrap_up_steps", 32'(st1 - base_st1), 32'd1);

        // Three-cycle glitch on A is rejected.
        snap();
        enc_a = 1'b1;
        cyc(3);
        enc_a = 1'b0;
        cyc(12);
        chk("glitch3_value", 32'(bus0.value), 32'd1);
        chk("glitch3_steps", 32'(st0 - base_st0), 32'd0);
        chk("glitch3_error", 32'(er0 - base_er0), 32'd0);

        // Four-cycle pulse on A is accepted: one up, then one down.
        snap();
        enc_a = 1'b1;
        cyc(4);
        enc_a = 1'b0;
        cyc(14);
        chk("pulse4_value", 32'(bus0.value), 32'd1);
        chk("pulse4_steps", 32'(st0 - base_st0), 32'd2);
        chk("pulse4_dir",   32'(bus0.dir),   32'd0);
        chk("pulse4_wrapdut", 32'(bus1.value), 32'd0);

        // Disabled transitions track direction but never count or catch up.
        snap();
        en = 1'b0;
        phase(1'b1, 1'b0);
        phase(1'b1, 1'b1);
        chk("en0_value", 32'(bus0.value), 32'd1);
        chk("en0_dir",   32'(bus0.dir),   32'd1);
        chk("en0_steps", 32'(st0 - base_st0), 32'd0);
        en = 1'b1;
        phase(1'b0, 1'b1);
        chk("en1_value",   32'(bus0.value), 32'd2);
        chk("en1_wrapdut", 32'(bus1.value), 32'd1);
        chk("en1_steps",   32'(st0 - base_st0), 32'd1);

        // Reset while a debounce is in flight clears everything on the next edge.
        enc_a = 1'b1;
        cyc(3);
        reset = 1'b1;
        cyc(1);
        chk("midrst_value", 32'(bus0.value), 32'd0);
        chk("midrst_dir",   32'(bus0.dir),   32'd0);
        chk("midrst_step",  32'(bus0.step),  32'd0);
        chk("midrst_error", 32'(bus0.error), 32'd0);

        // Encoder resting at 11 through reset: one error at edge 7, no count.
        cyc(2);
        snap();
        reset = 1'b0;
        cyc(6);
        chk("rest11_err_e6", 32'(bus0.error), 32'd0);
        cyc(1);
        chk("rest11_err_e7",  32'(bus0.error), 32'd1);
        chk("rest11_step_e7", 32'(bus0.step),  32'd0);
        chk("rest11_value",   32'(bus0.value), 32'd0);
        cyc(1);
        chk("rest11_err_e8", 32'(bus0.error), 32'd0);
        cyc(4);
        chk("rest11_errors", 32'(er0 - base_er0), 32'd1);
        chk("rest11_steps",  32'(st0 - base_st0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
